// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - instruction fetch PC sequencer with redirect, stall and memory-wait handling
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        branch_jump_mux_signal,
  input  logic [31:0] Branch_jump_PC_OUT,
  input  logic        stall,
  input  logic        imem_busywait,
  output logic        imem_read,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_4,
  output logic        fetch_valid,
  output logic        flush,
  output logic        misalign_err,
  output logic [15:0] redirect_count
);

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    FETCH      = 2'd1,
    WAIT_MEM   = 2'd2,
    REDIR_PEND = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        mis_q, mis_d;
  logic [15:0] cnt_q, cnt_d;

  logic        redir_acc;
  logic [31:0] tgt_aligned;
  logic [31:0] pc_inc;

  // Redirect targets are forced to word alignment; the low bits only feed the error flag.
  assign tgt_aligned = {Branch_jump_PC_OUT[31:2], 2'b00};
  assign pc_inc      = pc_q + 32'd4;

  assign PC             = pc_q;
  assign PC_plus_4      = pc_inc;
  assign misalign_err   = mis_q;
  assign redirect_count = cnt_q;

  // Output decode and next-state selection; priority is redirect, then memory wait, then stall.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    mis_d       = mis_q;
    cnt_d       = cnt_q;

    // Redirects arriving while still in BOOT are dropped entirely.
    redir_acc   = branch_jump_mux_signal && (state_q != BOOT);
    imem_read   = (state_q != BOOT);
    flush       = redir_acc || (state_q == REDIR_PEND);
    fetch_valid = ((state_q == FETCH) || (state_q == WAIT_MEM)) &&
                  !redir_acc && !imem_busywait && !stall;

    if (redir_acc) begin
      if (Branch_jump_PC_OUT[1:0] != 2'b00) begin
        mis_d = 1'b1;
      end
      if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH, WAIT_MEM: begin
        if (redir_acc) begin
          if (imem_busywait) begin
            pend_d  = tgt_aligned;
            state_d = REDIR_PEND;
          end else begin
            pc_d    = tgt_aligned;
            state_d = FETCH;
          end
        end else if (imem_busywait) begin
          state_d = WAIT_MEM;
        end else if (!stall) begin
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      REDIR_PEND: begin
        // The word returned for the old PC is discarded by the flush; only the target matters.
        if (redir_acc) begin
          if (imem_busywait) begin
            pend_d = tgt_aligned;
          end else begin
            pc_d    = tgt_aligned;
            state_d = FETCH;
          end
        end else if (!imem_busywait) begin
          pc_d    = pend_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State and datapath registers; reset discards any pending redirect target.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      pend_q  <= 32'h00000000;
      mis_q   <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        CLK;
  logic        RESET;
  logic        branch_jump_mux_signal;
  logic [31:0] Branch_jump_PC_OUT;
  logic        stall;
  logic        imem_busywait;
  logic        imem_read;
  logic [31:0] PC;
  logic [31:0] PC_plus_4;
  logic        fetch_valid;
  logic        flush;
  logic        misalign_err;
  logic [15:0] redirect_count;

  int n_cmp = 0;
  int n_err = 0;

  pc_fetch_unit #(.RESET_VECTOR(32'h00000000)) dut (
    .CLK                    (CLK),
    .RESET                  (RESET),
    .branch_jump_mux_signal (branch_jump_mux_signal),
    .Branch_jump_PC_OUT     (Branch_jump_PC_OUT),
    .stall                  (stall),
    .imem_busywait          (imem_busywait),
    .imem_read              (imem_read),
    .PC                     (PC),
    .PC_plus_4              (PC_plus_4),
    .fetch_valid            (fetch_valid),
    .flush                  (flush),
    .misalign_err           (misalign_err),
    .redirect_count         (redirect_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: a PC, a "still booting" flag and an optional pending target.
  bit          m_boot;
  bit          m_pend;
  logic [31:0] m_tgt;
  logic [31:0] m_pc;
  bit          m_mis;
  int          m_cnt;

  typedef struct {
    bit          br;
    logic [31:0] tgt;
    bit          st;
    bit          bz;
    logic [31:0] e_pc;
    bit          e_rd;
    bit          e_fv;
    bit          e_fl;
    bit          e_mis;
    int          e_cnt;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1;
    m_pend = 1'b0;
    m_tgt  = 32'h0;
    m_pc   = 32'h0;
    m_mis  = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic reset_dut();
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    branch_jump_mux_signal = 1'b0;
    Branch_jump_PC_OUT = 32'h0;
    stall = 1'b0;
    imem_busywait = 1'b0;
    #1;
    chk("rst_pc", PC, 32'h0);
    chk("rst_imem_read", {31'b0, imem_read}, 32'h0);
    chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_misalign", {31'b0, misalign_err}, 32'h0);
    chk("rst_count", {16'b0, redirect_count}, 32'h0);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    model_reset();
  endtask

  task automatic apply(input bit br, input logic [31:0] tgt, input bit st, input bit bz);
    @(negedge CLK);
    branch_jump_mux_signal = br;
    Branch_jump_PC_OUT = tgt;
    stall = st;
    imem_busywait = bz;
    #1;
  endtask

  // Compare against the model for the inputs just applied, then advance it by one clock.
  task automatic model_check();
    bit          acc;
    bit          e_fv;
    logic [31:0] t;
    acc  = branch_jump_mux_signal && !m_boot;
    e_fv = !m_boot && !m_pend && !acc && !imem_busywait && !stall;
    chk("m_pc", PC, m_pc);
    chk("m_pc_plus_4", PC_plus_4, m_pc + 32'd4);
    chk("m_imem_read", {31'b0, imem_read}, {31'b0, !m_boot});
    chk("m_flush", {31'b0, flush}, {31'b0, acc || m_pend});
    chk("m_fetch_valid", {31'b0, fetch_valid}, {31'b0, e_fv});
    chk("m_misalign", {31'b0, misalign_err}, {31'b0, m_mis});
    chk("m_count", {16'b0, redirect_count}, m_cnt);
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (acc) begin
      t = Branch_jump_PC_OUT & 32'hFFFF_FFFC;
      if (Branch_jump_PC_OUT % 4 != 0) m_mis = 1'b1;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (imem_busywait) begin
        m_pend = 1'b1;
        m_tgt  = t;
      end else begin
        m_pend = 1'b0;
        m_pc   = t;
      end
    end else if (m_pend) begin
      if (!imem_busywait) begin
        m_pc   = m_tgt;
        m_pend = 1'b0;
      end
    end else if (!imem_busywait && !stall) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    RESET = 1'b0;
    branch_jump_mux_signal = 1'b0;
    Branch_jump_PC_OUT = 32'h0;
    stall = 1'b0;
    imem_busywait = 1'b0;

    //          br  tgt            st bz  pc             rd fv fl mis cnt
    vecs[0]  = '{0, 32'h0,         0, 0, 32'h00000000, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 32'h0,         0, 0, 32'h00000000, 1, 1, 0, 0, 0};
    vecs[2]  = '{0, 32'h0,         0, 0, 32'h00000004, 1, 1, 0, 0, 0};
    vecs[3]  = '{0, 32'h0,         0, 0, 32'h00000008, 1, 1, 0, 0, 0};
    vecs[4]  = '{0, 32'h0,         0, 0, 32'h0000000C, 1, 1, 0, 0, 0};
    vecs[5]  = '{1, 32'h200,       0, 0, 32'h00000010, 1, 0, 1, 0, 0};
    vecs[6]  = '{1, 32'h80,        1, 0, 32'h00000200, 1, 0, 1, 0, 1};
    vecs[7]  = '{0, 32'h0,         1, 0, 32'h00000080, 1, 0, 0, 0, 2};
    vecs[8]  = '{0, 32'h0,         1, 0, 32'h00000080, 1, 0, 0, 0, 2};
    vecs[9]  = '{0, 32'h0,         0, 0, 32'h00000080, 1, 1, 0, 0, 2};
    vecs[10] = '{0, 32'h0,         0, 1, 32'h00000084, 1, 0, 0, 0, 2};
    vecs[11] = '{0, 32'h0,         0, 0, 32'h00000084, 1, 1, 0, 0, 2};
    vecs[12] = '{1, 32'hFFFFFFFE,  0, 0, 32'h00000088, 1, 0, 1, 0, 2};
    vecs[13] = '{0, 32'h0,         0, 0, 32'hFFFFFFFC, 1, 1, 0, 1, 3};
    vecs[14] = '{0, 32'h0,         0, 0, 32'h00000000, 1, 1, 0, 1, 3};

    // Table-driven directed sequence starting from reset.
    reset_dut();
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i].br, vecs[i].tgt, vecs[i].st, vecs[i].bz);
      chk($sformatf("v%0d_pc", i), PC, vecs[i].e_pc);
      chk($sformatf("v%0d_pc_plus_4", i), PC_plus_4, vecs[i].e_pc + 32'd4);
      chk($sformatf("v%0d_imem_read", i), {31'b0, imem_read}, {31'b0, vecs[i].e_rd});
      chk($sformatf("v%0d_fetch_valid", i), {31'b0, fetch_valid}, {31'b0, vecs[i].e_fv});
      chk($sformatf("v%0d_flush", i), {31'b0, flush}, {31'b0, vecs[i].e_fl});
      chk($sformatf("v%0d_misalign", i), {31'b0, misalign_err}, {31'b0, vecs[i].e_mis});
      chk($sformatf("v%0d_count", i), {16'b0, redirect_count}, vecs[i].e_cnt);
    end

    // Two redirects while memory is busy: the later target wins.
    reset_dut();
    apply(0, 32'h0, 0, 0);
    for (int i = 0; i < 8; i++) apply(0, 32'h0, 0, 0);
    apply(1, 32'h400, 0, 1);
    chk("pend_pc_start", PC, 32'h20);
    chk("pend_flush_c1", {31'b0, flush}, 32'h1);
    apply(1, 32'h500, 0, 1);
    chk("pend_flush_c2", {31'b0, flush}, 32'h1);
    chk("pend_pc_hold", PC, 32'h20);
    apply(0, 32'h0, 0, 1);
    chk("pend_flush_c3", {31'b0, flush}, 32'h1);
    chk("pend_fv_c3", {31'b0, fetch_valid}, 32'h0);
    apply(0, 32'h0, 0, 0);
    chk("pend_flush_drop", {31'b0, flush}, 32'h1);
    chk("pend_fv_drop", {31'b0, fetch_valid}, 32'h0);
    apply(0, 32'h0, 0, 0);
    chk("pend_pc_final", PC, 32'h500);
    chk("pend_count", {16'b0, redirect_count}, 32'd2);
    chk("pend_fv_final", {31'b0, fetch_valid}, 32'h1);

    // Asynchronous reset while a redirect is pending drops the target.
    reset_dut();
    apply(0, 32'h0, 0, 0);
    apply(0, 32'h0, 0, 0);
    apply(1, 32'h300, 0, 1);
    apply(0, 32'h0, 0, 1);
    chk("ar_flush_pending", {31'b0, flush}, 32'h1);
    #2;
    RESET = 1'b0;
    #1;
    chk("ar_pc", PC, 32'h0);
    chk("ar_flush", {31'b0, flush}, 32'h0);
    chk("ar_imem_read", {31'b0, imem_read}, 32'h0);
    chk("ar_count", {16'b0, redirect_count}, 32'h0);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    imem_busywait = 1'b0;
    apply(0, 32'h0, 0, 0);
    chk("ar_boot_read", {31'b0, imem_read}, 32'h0);
    chk("ar_boot_pc", PC, 32'h0);
    apply(0, 32'h0, 0, 0);
    chk("ar_first_pc", PC, 32'h0);
    chk("ar_first_fv", {31'b0, fetch_valid}, 32'h1);
    apply(0, 32'h0, 0, 0);
    chk("ar_second_pc", PC, 32'h4);

    // Randomized traffic against the reference model, with occasional resets.
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      if ($urandom_range(0, 399) == 0) begin
        reset_dut();
      end
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      apply($urandom_range(0, 5) == 0, t, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
      model_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h00000000, first fetch address after reset.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset; RESET=0 clears all state immediately, independent of CLK.
REQ-004 branch_jump_mux_signal  input  1  redirect request from the branch/jump controller, valid for the current cycle.
REQ-005 Branch_jump_PC_OUT  input  32  redirect target address, qualified by branch_jump_mux_signal.
REQ-006 stall  input  1  hazard-unit stall request; hold PC.
REQ-007 imem_busywait  input  1  instruction memory not ready; current fetch incomplete.
REQ-008 imem_read  output  1  instruction memory read enable.
REQ-009 PC  output  32  current fetch address (registered).
REQ-010 PC_plus_4  output  32  PC+4, combinational.
REQ-011 fetch_valid  output  1  fetched word at PC is valid for IF/ID this cycle.
REQ-012 flush  output  1  kill the IF/ID contents this cycle.
REQ-013 misalign_err  output  1  sticky flag: a redirect target had nonzero bits [1:0].
REQ-014 redirect_count  output  16  number of accepted redirects, saturating.

Function
REQ-015 FSM states: BOOT, FETCH, WAIT_MEM, REDIR_PEND; encoding is implementation-defined.
REQ-016 BOOT: imem_read=0, fetch_valid=0, flush=0; next state is unconditionally FETCH; PC stays RESET_VECTOR.
REQ-017 FETCH/WAIT_MEM: imem_read=1.
REQ-018 In FETCH, imem_busywait=1 without redirect: PC holds; next state is WAIT_MEM; fetch_valid=0.
REQ-019 In FETCH or WAIT_MEM, imem_busywait=0, stall=0, no redirect: fetch_valid=1; PC <= PC+4; next state is FETCH.
REQ-020 Redirect is accepted when branch_jump_mux_signal=1 in FETCH, WAIT_MEM or REDIR_PEND; flush=1 combinationally in the same cycle; fetch_valid=0 in that cycle.
REQ-021 Accepted redirect with imem_busywait=0: PC <= {Branch_jump_PC_OUT[31:2],2'b00} at the next edge; next state is FETCH.
REQ-022 Accepted redirect with imem_busywait=1: target latched into a pending register; PC holds; next state is REDIR_PEND.
REQ-023 REDIR_PEND: imem_read=1, fetch_valid=0, flush=1 every cycle; when imem_busywait=0, PC <= pending target and next state is FETCH; the returned word is discarded.
REQ-024 A new redirect in REDIR_PEND overwrites the pending target; the last target wins.
REQ-025 Priority: redirect > imem_busywait > stall.
REQ-026 stall=1, no redirect, imem_busywait=0: PC holds; fetch_valid=0; state unchanged.
REQ-027 PC arithmetic is modulo 2^32: PC=32'hFFFFFFFC gives PC_plus_4=32'h00000000 and wraps the same way on increment.
REQ-028 Each accepted redirect with Branch_jump_PC_OUT[1:0]!=0 sets misalign_err=1; it stays set until reset.
REQ-029 redirect_count increments by 1 per accepted redirect per cycle (REDIR_PEND overwrites included); it saturates at 16'hFFFF.
REQ-030 A redirect request in BOOT is ignored: no flush, no count.

Reset
REQ-031 While RESET=0: state=BOOT, PC=RESET_VECTOR, pending target=0, misalign_err=0, redirect_count=0, imem_read=0, fetch_valid=0, flush=0.
REQ-032 An assertion of RESET mid-WAIT_MEM or mid-REDIR_PEND discards the pending target; the first fetch after release is at RESET_VECTOR, after one BOOT cycle.

Verification
REQ-033 Release reset, busywait=0: BOOT for one cycle, then PC=0,4,8,... with fetch_valid=1 every cycle.
REQ-034 PC=0x10, redirect target 0x200: flush=1 that cycle; next PC=0x200; redirect_count=1.
REQ-035 PC=0x20, busywait=1 for 3 cycles, redirect 0x400 in cycle 1, redirect 0x500 in cycle 2: flush=1 for cycles 1-3; PC=0x500 after busywait drops; count=2.
REQ-036 stall=1 and redirect 0x80 in the same cycle: PC=0x80 next cycle; stall alone holds PC for 2 cycles with fetch_valid=0.
REQ-037 Redirect target 0xFFFFFFFE: PC=0xFFFFFFFC, misalign_err=1; next increment gives PC=0x00000000; misalign_err stays 1.
REQ-038 Assert RESET during REDIR_PEND (pending 0x300): all outputs take reset values asynchronously; after release the first PC fetched is RESET_VECTOR, not 0x300.
